// File: rtl/halut_ctrl_pkg.sv
// Shared types and width helpers for the HALUT matmul sequencer.
package halut_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    TGT_ENC = 1'b0,
    TGT_DEC = 1'b1
  } cfg_target_e;

  localparam int unsigned MAX_IN_FLIGHT_DEFAULT = 4;

  function automatic int unsigned thresh_addr_width(int unsigned c, int unsigned k,
                                                    int unsigned enc_units);
    return $clog2((c / enc_units) * k);
  endfunction

  function automatic int unsigned total_addr_width(int unsigned c, int unsigned k);
    return $clog2(c * k);
  endfunction

  // Never returns zero so a single-unit build still gets a 1-bit index port.
  function automatic int unsigned unit_width(int unsigned a, int unsigned b);
    int unsigned w;
    w = (a > b) ? $clog2(a) : $clog2(b);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/halut_result_counter.sv
// Accumulates decoder result strobes, retires a row every M strobes and
// tracks how many admitted rows are still waiting for their results.
module halut_result_counter
  import halut_ctrl_pkg::*;
#(
  parameter int unsigned M           = 32,
  parameter int unsigned DecUnitsX   = 2,
  parameter int unsigned MaxInFlight = MAX_IN_FLIGHT_DEFAULT,
  localparam int unsigned OutWidth   = $clog2(MaxInFlight + 1),
  localparam int unsigned CntWidth   = $clog2(M + DecUnitsX)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 i_en,
  input  logic [DecUnitsX-1:0] i_dec_valid,
  input  logic                 i_issue,
  output logic                 o_retire,
  output logic [OutWidth-1:0]  o_outstanding,
  output logic                 o_res_zero
);

  logic [CntWidth-1:0] r_res_cnt;
  logic [CntWidth-1:0] w_pop;
  logic [CntWidth-1:0] w_sum;
  logic [OutWidth-1:0] r_outstanding;
  logic                w_dec;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < DecUnitsX; i++) begin
      w_pop = w_pop + CntWidth'(i_dec_valid[i]);
    end
  end

  assign w_sum    = r_res_cnt + (i_en ? w_pop : '0);
  assign o_retire = i_en && (w_sum >= CntWidth'(M));
  // Never let a surplus retire wrap the in-flight count below zero.
  assign w_dec    = o_retire && ((r_outstanding != '0) || i_issue);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_res_cnt     <= '0;
      r_outstanding <= '0;
    end else begin
      r_res_cnt <= o_retire ? (w_sum - CntWidth'(M)) : w_sum;
      if (i_issue && !w_dec) begin
        r_outstanding <= r_outstanding + OutWidth'(1);
      end else if (!i_issue && w_dec) begin
        r_outstanding <= r_outstanding - OutWidth'(1);
      end
    end
  end

  assign o_outstanding = r_outstanding;
  assign o_res_zero    = (r_res_cnt == '0);

endmodule

// File: rtl/halut_matmul_ctrl.sv
// Config router, credit-limited row issuer and batch-completion sequencer
// for the HALUT encoder/decoder datapath.
module halut_matmul_ctrl
  import halut_ctrl_pkg::*;
#(
  parameter int unsigned K                  = 16,
  parameter int unsigned C                  = 32,
  parameter int unsigned M                  = 32,
  parameter int unsigned DataTypeWidth      = 16,
  parameter int unsigned EncUnits           = 4,
  parameter int unsigned DecoderUnits       = 16,
  parameter int unsigned DecUnitsX          = M / DecoderUnits,
  parameter int unsigned CPerEncUnit        = C / EncUnits,
  parameter int unsigned ThreshMemAddrWidth = thresh_addr_width(C, K, EncUnits),
  parameter int unsigned TotalAddrWidth     = total_addr_width(C, K),
  parameter int unsigned MaxInFlight        = MAX_IN_FLIGHT_DEFAULT,
  parameter int unsigned RowCntWidth        = 16,
  localparam int unsigned UnitWidth         = unit_width(EncUnits, DecUnitsX)
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic                                          cfg_valid_i,
  output logic                                          cfg_ready_o,
  input  logic                                          cfg_target_i,
  input  logic [UnitWidth-1:0]                          cfg_unit_i,
  input  logic [TotalAddrWidth-1:0]                     cfg_addr_i,
  input  logic [DataTypeWidth-1:0]                      cfg_data_i,
  input  logic                                          start_i,
  input  logic [RowCntWidth-1:0]                        num_rows_i,
  input  logic                                          row_valid_i,
  output logic                                          row_ready_o,
  output logic [EncUnits-1:0]                           we_enc_o,
  output logic [EncUnits-1:0][ThreshMemAddrWidth-1:0]   waddr_enc_o,
  output logic [EncUnits-1:0][DataTypeWidth-1:0]        wdata_enc_o,
  output logic                                          encoder_o,
  output logic [DecUnitsX-1:0]                          we_dec_o,
  output logic [DecUnitsX-1:0][TotalAddrWidth-1:0]      waddr_dec_o,
  output logic [DecUnitsX-1:0][DataTypeWidth-1:0]       wdata_dec_o,
  input  logic [DecUnitsX-1:0]                          dec_valid_i,
  output logic                                          busy_o,
  output logic                                          done_o,
  output logic                                          err_o,
  output logic [RowCntWidth-1:0]                        rows_done_o
);

  localparam int unsigned BeatWidth = (CPerEncUnit > 1) ? $clog2(CPerEncUnit) : 1;
  localparam int unsigned OutWidth  = $clog2(MaxInFlight + 1);
  localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(CPerEncUnit - 1);

  state_e                  r_state, w_state_next;
  logic [BeatWidth-1:0]    r_beat;
  logic [RowCntWidth-1:0]  r_num_rows;
  logic [RowCntWidth-1:0]  r_rows_issued;
  logic                    r_err;
  logic                    w_cfg_fire, w_cfg_unit_ok, w_start;
  logic                    w_row_last, w_last_row, w_mid_gap, w_dec_stray;
  logic                    w_count_en, w_retire, w_res_zero;
  logic [OutWidth-1:0]     w_outstanding;
  logic [EncUnits-1:0]     w_enc_sel;
  logic [DecUnitsX-1:0]    w_dec_sel;

  assign cfg_ready_o   = (r_state == ST_IDLE);
  assign w_cfg_fire    = cfg_valid_i && cfg_ready_o;
  assign w_cfg_unit_ok = (cfg_target_i == TGT_ENC) ? (32'(cfg_unit_i) < EncUnits)
                                                   : (32'(cfg_unit_i) < DecUnitsX);

  for (genvar gi = 0; gi < EncUnits; gi++) begin : g_enc_sel
    assign w_enc_sel[gi] = w_cfg_fire && (cfg_target_i == TGT_ENC) &&
                           (cfg_unit_i == UnitWidth'(gi));
  end
  for (genvar gi = 0; gi < DecUnitsX; gi++) begin : g_dec_sel
    assign w_dec_sel[gi] = w_cfg_fire && (cfg_target_i == TGT_DEC) &&
                           (cfg_unit_i == UnitWidth'(gi));
  end

  // Address/data registers only move on their own unit's write and otherwise hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_enc_o    <= '0;
      waddr_enc_o <= '0;
      wdata_enc_o <= '0;
      we_dec_o    <= '0;
      waddr_dec_o <= '0;
      wdata_dec_o <= '0;
    end else begin
      for (int i = 0; i < EncUnits; i++) begin
        we_enc_o[i] <= w_enc_sel[i];
        if (w_enc_sel[i]) begin
          waddr_enc_o[i] <= cfg_addr_i[ThreshMemAddrWidth-1:0];
          wdata_enc_o[i] <= cfg_data_i;
        end
      end
      for (int i = 0; i < DecUnitsX; i++) begin
        we_dec_o[i] <= w_dec_sel[i];
        if (w_dec_sel[i]) begin
          waddr_dec_o[i] <= cfg_addr_i;
          wdata_dec_o[i] <= cfg_data_i;
        end
      end
    end
  end

  assign w_start     = start_i && (r_state == ST_IDLE);
  assign row_ready_o = (r_state == ST_RUN) &&
                       ((r_beat != '0) || (w_outstanding < OutWidth'(MaxInFlight)));
  assign encoder_o   = row_valid_i && row_ready_o;
  assign w_row_last  = encoder_o && (r_beat == LastBeat);
  assign w_last_row  = w_row_last && ((r_rows_issued + RowCntWidth'(1)) == r_num_rows);
  assign w_mid_gap   = (r_state == ST_RUN) && (r_beat != '0) && !row_valid_i;
  assign w_count_en  = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_dec_stray = !w_count_en && (|dec_valid_i);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (start_i) w_state_next = (num_rows_i == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (w_last_row) w_state_next = ST_DRAIN;
      ST_DRAIN: if ((w_outstanding == '0) && w_res_zero) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= ST_IDLE;
      r_beat        <= '0;
      r_num_rows    <= '0;
      r_rows_issued <= '0;
      rows_done_o   <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_num_rows    <= num_rows_i;
        r_rows_issued <= '0;
        r_beat        <= '0;
      end else if (encoder_o) begin
        r_beat <= w_row_last ? '0 : (r_beat + BeatWidth'(1));
        if (w_row_last) r_rows_issued <= r_rows_issued + RowCntWidth'(1);
      end
      if (w_start) begin
        rows_done_o <= '0;
      end else if (w_retire) begin
        rows_done_o <= rows_done_o + RowCntWidth'(1);
      end
      if ((w_cfg_fire && !w_cfg_unit_ok) || w_mid_gap || w_dec_stray) r_err <= 1'b1;
    end
  end

  halut_result_counter #(
    .M           (M),
    .DecUnitsX   (DecUnitsX),
    .MaxInFlight (MaxInFlight)
  ) u_result_counter (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .i_en          (w_count_en),
    .i_dec_valid   (dec_valid_i),
    .i_issue       (w_row_last),
    .o_retire      (w_retire),
    .o_outstanding (w_outstanding),
    .o_res_zero    (w_res_zero)
  );

  assign busy_o = (r_state != ST_IDLE);
  assign done_o = (r_state == ST_DONE);
  assign err_o  = r_err;

endmodule
